// File: rtl/mcpu_irom_loader_if.sv
// Byte-stream valid/ready channel that carries a framed program image into the loader.
interface mcpu_irom_loader_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/mcpu_irom_loader.sv
// Boot-time instruction store: accepts a length/payload/checksum frame, holds the core in
// reset while loading, then serves instruction bytes combinationally for the core's pc.
module mcpu_irom_loader #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    mcpu_irom_loader_if.slave     in_bus,
    input  logic                  reload,
    input  logic [DATA_WIDTH-1:0] pc,
    output logic [7:0]            irom_out,
    output logic                  core_reset,
    output logic                  loaded,
    output logic                  error,
    output logic [1:0]            err_code,
    output logic [15:0]           prog_len
);

    localparam int unsigned DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [16:0] DepthLen = 17'(DEPTH);
    localparam int unsigned CmpW     = (DATA_WIDTH > 16) ? DATA_WIDTH : 16;
    localparam logic [ADDR_WIDTH:0] PtrOne = 1;

    typedef enum logic [2:0] {
        StLenHi,
        StLenLo,
        StData,
        StCsum,
        StRun,
        StErr
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          len_hi_q, len_hi_d;
    logic [15:0]         len_q, len_d;
    logic [ADDR_WIDTH:0] wptr_q, wptr_d;
    logic [7:0]          acc_q, acc_d;
    logic [1:0]          err_code_q, err_code_d;
    logic [15:0]         prog_len_q, prog_len_d;
    logic                core_reset_q;

    logic [7:0]          mem [DEPTH];
    logic                mem_we;
    logic                accepting;
    logic                hs;
    logic [15:0]         len_full;
    logic [7:0]          csum;
    logic [CmpW-1:0]     pc_ext;
    logic [CmpW-1:0]     len_ext;

    assign accepting = (state_q == StLenHi) || (state_q == StLenLo) ||
                       (state_q == StData)  || (state_q == StCsum);
    assign in_bus.in_ready = accepting & ~reload;
    assign hs        = in_bus.in_valid & in_bus.in_ready;
    assign len_full  = {len_hi_q, in_bus.in_data};
    assign csum      = acc_q + in_bus.in_data;

    always_comb begin
        state_d    = state_q;
        len_hi_d   = len_hi_q;
        len_d      = len_q;
        wptr_d     = wptr_q;
        acc_d      = acc_q;
        err_code_d = err_code_q;
        prog_len_d = prog_len_q;
        mem_we     = 1'b0;

        if (reload) begin
            // Discard everything; the byte on the bus this cycle is not consumed.
            state_d    = StLenHi;
            err_code_d = 2'd0;
            prog_len_d = 16'd0;
        end else if (hs) begin
            case (state_q)
                StLenHi: begin
                    len_hi_d = in_bus.in_data;
                    state_d  = StLenLo;
                end
                StLenLo: begin
                    if ((len_full == 16'd0) || ({1'b0, len_full} > DepthLen)) begin
                        state_d    = StErr;
                        err_code_d = 2'd1;
                    end else begin
                        len_d   = len_full;
                        wptr_d  = '0;
                        acc_d   = 8'd0;
                        state_d = StData;
                    end
                end
                StData: begin
                    mem_we = 1'b1;
                    wptr_d = wptr_q + PtrOne;
                    acc_d  = csum;
                    if (17'(wptr_q) + 17'd1 == {1'b0, len_q}) begin
                        state_d = StCsum;
                    end
                end
                StCsum: begin
                    if (csum == 8'd0) begin
                        state_d    = StRun;
                        prog_len_d = len_q;
                    end else begin
                        state_d    = StErr;
                        err_code_d = 2'd2;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StLenHi;
            len_hi_q     <= 8'd0;
            len_q        <= 16'd0;
            wptr_q       <= '0;
            acc_q        <= 8'd0;
            err_code_q   <= 2'd0;
            prog_len_q   <= 16'd0;
            core_reset_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            len_hi_q     <= len_hi_d;
            len_q        <= len_d;
            wptr_q       <= wptr_d;
            acc_q        <= acc_d;
            err_code_q   <= err_code_d;
            prog_len_q   <= prog_len_d;
            // Tracks next state so the core leaves reset on the very edge that enters run.
            core_reset_q <= (state_d != StRun);
        end
    end

    // Program memory survives reset and reload; only bytes below prog_len are ever read out.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wptr_q[ADDR_WIDTH-1:0]] <= in_bus.in_data;
        end
    end

    assign pc_ext  = CmpW'(pc);
    assign len_ext = CmpW'(prog_len_q);

    always_comb begin
        irom_out = 8'h00;
        if ((state_q == StRun) && (pc_ext < len_ext)) begin
            irom_out = mem[pc[ADDR_WIDTH-1:0]];
        end
    end

    assign core_reset = core_reset_q;
    assign loaded     = (state_q == StRun);
    assign error      = (state_q == StErr);
    assign err_code   = err_code_q;
    assign prog_len   = prog_len_q;

endmodule

// File: tb/tb_mcpu_irom_loader.sv
// Randomized and directed bench for mcpu_irom_loader against a frame-level reference model.
module tb_mcpu_irom_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        reload;
    logic [31:0] pc;
    logic [7:0]  irom_out;
    logic        core_reset;
    logic        loaded;
    logic        error;
    logic [1:0]  err_code;
    logic [15:0] prog_len;

    int n_checks = 0;
    int n_errs   = 0;
    int hs_cnt   = 0;

    mcpu_irom_loader_if sif ();

    mcpu_irom_loader #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (10)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_bus     (sif),
        .reload     (reload),
        .pc         (pc),
        .irom_out   (irom_out),
        .core_reset (core_reset),
        .loaded     (loaded),
        .error      (error),
        .err_code   (err_code),
        .prog_len   (prog_len)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sif.in_valid && sif.in_ready) hs_cnt <= hs_cnt + 1;
    end

    // Reference model: outcome of a whole frame, computed from the frame rules.
    logic [7:0] m_mem [1024];
    bit         m_loaded;
    bit         m_err;
    int         m_code;
    int         m_len;
    logic [7:0] frame [$];
    int         n_consume;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_loaded = 1'b0;
        m_err    = 1'b0;
        m_code   = 0;
        m_len    = 0;
    endtask

    task automatic model_apply();
        int n;
        int sum;
        n = int'(frame[0]) * 256 + int'(frame[1]);
        if (n == 0 || n > 1024) begin
            m_err     = 1'b1;
            m_code    = 1;
            n_consume = 2;
            return;
        end
        sum = 0;
        for (int i = 0; i < n; i++) begin
            m_mem[i] = frame[2+i];
            sum += int'(frame[2+i]);
        end
        n_consume = n + 3;
        if ((sum + int'(frame[n+2])) % 256 == 0) begin
            m_loaded = 1'b1;
            m_len    = n;
        end else begin
            m_err  = 1'b1;
            m_code = 2;
        end
    endtask

    function automatic logic [7:0] exp_irom(input logic [31:0] p);
        if (m_loaded && (p < 32'(m_len))) return m_mem[p[9:0]];
        return 8'h00;
    endfunction

    // Drives one byte (after an optional idle gap) and returns 1ns after its transfer edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit done;
        if (gap > 0) begin
            sif.in_valid = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
        end
        sif.in_data  = b;
        sif.in_valid = 1'b1;
        done = 1'b0;
        for (int t = 0; t < 20 && !done; t++) begin
            @(negedge clk);
            if (sif.in_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        if (!done) check("handshake_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_frame(input int max_gap);
        model_apply();
        for (int i = 0; i < n_consume; i++) begin
            send_byte(frame[i], (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0);
        end
    endtask

    task automatic idle();
        sif.in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reload();
        reload       = 1'b1;
        sif.in_valid = 1'b0;
        @(posedge clk);
        #1;
        reload = 1'b0;
        model_clear();
    endtask

    task automatic check_status(input string tag);
        check({tag, "_loaded"}, 32'(loaded), 32'(m_loaded));
        check({tag, "_error"}, 32'(error), 32'(m_err));
        check({tag, "_err_code"}, 32'(err_code), 32'(m_code));
        check({tag, "_prog_len"}, 32'(prog_len), 32'(m_len));
        check({tag, "_core_reset"}, 32'(core_reset), 32'(!m_loaded));
        check({tag, "_in_ready"}, 32'(sif.in_ready), 32'(!(m_loaded || m_err)));
    endtask

    task automatic check_pc(input string tag, input logic [31:0] p);
        pc = p;
        #1;
        check(tag, 32'(irom_out), 32'(exp_irom(p)));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] t1_pc  [5];
        logic [7:0]  t1_exp [5];
        int          h0;
        int          len;
        int          sum;
        logic [7:0]  cs;

        reset        = 1'b0;
        reload       = 1'b0;
        pc           = 32'd0;
        sif.in_data  = 8'h00;
        sif.in_valid = 1'b0;
        model_clear();
        #12;
        check_status("reset");
        check("reset_irom", 32'(irom_out), 32'h0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Scenario 1: back-to-back valid frame
        frame = '{8'h00, 8'h03, 8'h81, 8'h9A, 8'h05, 8'hE0};
        send_frame(0);
        check_status("t1");
        t1_pc  = '{32'd0, 32'd1, 32'd2, 32'd3, 32'hFFFF_FFFF};
        t1_exp = '{8'h81, 8'h9A, 8'h05, 8'h00, 8'h00};
        for (int i = 0; i < 5; i++) begin
            pc = t1_pc[i];
            #1;
            check("t1_irom", 32'(irom_out), 32'(t1_exp[i]));
        end
        idle();

        // Scenario 2: checksum mismatch, then recovery
        do_reload();
        frame = '{8'h00, 8'h03, 8'h81, 8'h9A, 8'h05, 8'hE1};
        send_frame(0);
        idle();
        check_status("t2_bad");
        for (int i = 0; i < 4; i++) check_pc("t2_irom_err", 32'(i));
        do_reload();
        frame = '{8'h00, 8'h03, 8'h81, 8'h9A, 8'h05, 8'hE0};
        send_frame(0);
        idle();
        check_status("t2_good");

        // Scenario 3: length boundaries
        do_reload();
        frame = '{8'h00, 8'h00};
        send_frame(0);
        idle();
        check_status("t3_zero");
        do_reload();
        frame = '{8'h04, 8'h01};
        send_frame(0);
        idle();
        check_status("t3_over");
        do_reload();
        frame = '{8'h04, 8'h00};
        for (int i = 0; i < 1024; i++) frame.push_back(8'h01);
        frame.push_back(8'h00);
        send_frame(0);
        idle();
        check_status("t3_full");
        check_pc("t3_last", 32'd1023);
        check("t3_last_const", 32'(irom_out), 32'h01);
        check_pc("t3_past", 32'd1024);

        // Scenario 4: random gaps, exactly six transfers
        do_reload();
        h0 = hs_cnt;
        frame = '{8'h00, 8'h03, 8'h81, 8'h9A, 8'h05, 8'hE0};
        send_frame(5);
        idle();
        check("t4_hs_count", 32'(hs_cnt - h0), 32'd6);
        check_status("t4");
        for (int i = 0; i < 4; i++) check_pc("t4_irom", 32'(i));

        // Scenario 5: reload mid-payload with a byte offered
        do_reload();
        send_byte(8'h00, 0);
        send_byte(8'h03, 0);
        send_byte(8'hAA, 0);
        reload      = 1'b1;
        sif.in_data = 8'hBB;
        #1;
        check("t5_ready_in_reload", 32'(sif.in_ready), 32'd0);
        h0 = hs_cnt;
        @(posedge clk);
        #1;
        check("t5_no_consume", 32'(hs_cnt), 32'(h0));
        reload       = 1'b0;
        sif.in_valid = 1'b0;
        model_clear();
        #1;
        check_status("t5_after");
        frame = '{8'h00, 8'h01, 8'h7F, 8'h81};
        send_frame(0);
        idle();
        check_status("t5_frame");
        check_pc("t5_pc0", 32'd0);

        // Scenario 6: async reset mid-payload and while running
        do_reload();
        send_byte(8'h00, 0);
        send_byte(8'h05, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        sif.in_valid = 1'b0;
        pc = 32'd0;
        @(posedge clk);
        #3;
        reset = 1'b0;
        model_clear();
        #1;
        check_status("t6_data_rst");
        check("t6_data_irom", 32'(irom_out), 32'h0);
        @(posedge clk);
        #4;
        reset = 1'b1;
        frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hBA};
        send_frame(0);
        idle();
        check_status("t6_frame");
        check_pc("t6_pc1", 32'd1);
        pc = 32'd0;
        @(posedge clk);
        #3;
        reset = 1'b0;
        model_clear();
        #1;
        check_status("t6_run_rst");
        check("t6_run_irom", 32'(irom_out), 32'h0);
        @(posedge clk);
        #4;
        reset = 1'b1;
        frame = '{8'h00, 8'h01, 8'h55, 8'hAB};
        send_frame(2);
        idle();
        check_status("t6_again");
        check_pc("t6_again_pc0", 32'd0);

        // Randomized frames
        for (int it = 0; it < 40; it++) begin
            do_reload();
            case ($urandom_range(9, 0))
                0:       len = 0;
                1:       len = 1025 + int'($urandom_range(200, 0));
                default: len = int'($urandom_range(48, 1));
            endcase
            frame = {};
            frame.push_back(8'(len >> 8));
            frame.push_back(8'(len));
            sum = 0;
            for (int i = 0; i < len && len <= 1024; i++) begin
                frame.push_back(8'($urandom));
                sum += int'(frame[frame.size()-1]);
            end
            cs = 8'((256 - (sum % 256)) % 256);
            if ($urandom_range(3, 0) == 0) cs = cs ^ 8'($urandom_range(255, 1));
            frame.push_back(cs);
            send_frame(3);
            idle();
            check_status("rand");
            for (int k = 0; k < 6; k++) check_pc("rand_irom", $urandom_range(len + 2, 0));
            check_pc("rand_irom_hi", {$urandom_range(255, 1), 24'($urandom)});
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/mcpu_irom_loader.md
Name: mcpu_irom_loader

Overview:
Boot-time instruction store and loader that sits directly upstream of the MCPU core. It receives a framed program image over a byte-stream valid/ready interface and writes it into internal byte-wide instruction memory. While loading, it holds the core in reset. Once a frame is validated, it releases the core and serves instruction bytes combinationally for the core's program counter.

Parameters:
DATA_WIDTH, 32, width of the core program counter input
ADDR_WIDTH, 10, instruction memory address width; DEPTH = 2^ADDR_WIDTH bytes; legal range 1..16

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
in_data  input  8  stream byte
in_valid  input  1  stream byte valid
in_ready  output  1  loader accepts byte; transfer when in_valid & in_ready
reload  input  1  synchronous request to discard the current program and accept a new frame
pc  input  DATA_WIDTH  core program counter (core cnt_pc)
irom_out  output  8  instruction byte to core irom_in
core_reset  output  1  active-high synchronous reset to core; registered
loaded  output  1  valid program present, core running
error  output  1  frame rejected
err_code  output  2  0 = none, 1 = bad length, 2 = checksum mismatch
prog_len  output  16  accepted program length in bytes

Behaviour:
- Frame format, in order:
  - LEN_HI byte, then LEN_LO byte: 16-bit big-endian length N.
  - N payload bytes, written to addresses 0..N-1.
  - One CSUM byte. The frame is valid iff (sum of payload bytes + CSUM) mod 256 == 0.
- States: S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_RUN, S_ERR.
- in_ready = (state is S_LEN_HI, S_LEN_LO, S_DATA or S_CSUM) & ~reload. It is combinational.
- Transitions (on handshake unless noted):
  - S_LEN_HI -> S_LEN_LO: latch high byte.
  - S_LEN_LO: if N == 0 or N > DEPTH -> S_ERR with err_code = 1. Otherwise -> S_DATA; clear write pointer and checksum accumulator.
  - S_DATA: write mem[wptr] = in_data, wptr += 1, acc += in_data (8-bit wrap). After the Nth byte -> S_CSUM.
  - S_CSUM: if (acc + in_data) mod 256 == 0 -> S_RUN. Otherwise -> S_ERR with err_code = 2.
  - S_RUN / S_ERR: hold until reload.
  - reload = 1 in any state -> S_LEN_HI on the next edge. This discards any partial frame and clears loaded, error, err_code and prog_len. No byte is consumed in that cycle.
- Cycles with in_valid = 0 do not advance state. Gaps of any length are legal.
- core_reset register loads (next_state != S_RUN) each cycle:
  - It falls on the same edge that enters S_RUN.
  - The core therefore begins at pc = 0 with the full program resident.
  - It rises on the same edge that leaves S_RUN.
- loaded = 1 exactly while in S_RUN. error = 1 exactly while in S_ERR.
- prog_len is set on entry to S_RUN and holds N; it is 0 otherwise.
- irom_out:
  - In S_RUN with pc < prog_len (full-width unsigned compare): mem[pc[ADDR_WIDTH-1:0]], combinational async read.
  - Otherwise 0x00, which is the core halt encoding.
- Memory is not cleared by reset or reload; contents beyond prog_len are never output.
- Async reset (reset = 0) takes effect immediately, independent of clk, including mid-frame:
  - state = S_LEN_HI, core_reset = 1, loaded = 0, error = 0, err_code = 0, prog_len = 0, wptr = 0, acc = 0.
  - irom_out = 0x00; in_ready = 1 once reload = 0.
- Release is synchronous to the normal clock edge.

Test Plan:
1. Reset; stream 00 03 81 9A 05 E0 with in_valid held high -> in_ready low from the edge after E0. In that same cycle loaded = 1, core_reset = 0, prog_len = 3. Then pc = 0/1/2/3/0xFFFF_FFFF -> irom_out = 0x81/0x9A/0x05/0x00/0x00.
2. Same frame with CSUM = E1 -> error = 1, err_code = 2, core_reset stays 1, in_ready = 0, irom_out = 0x00 for all pc. Pulse reload, then send the valid frame -> loaded = 1, error = 0.
3. Length 00 00 -> S_ERR with err_code = 1 immediately after LEN_LO. With ADDR_WIDTH = 10, length 04 01 -> err_code = 1 and length 04 00 is accepted. For the 04 00 case, send 1024 bytes of 0x01 (sum 0x00) plus CSUM 00 -> loaded = 1, and pc = 1023 -> 0x01.
4. Send frame 1 with random in_valid gaps (0-5 idle cycles) -> identical result to scenario 1; exactly 6 handshakes counted.
5. In S_DATA after 1 payload byte, assert reload with in_valid = 1 -> in_ready = 0, byte not consumed, state S_LEN_HI next cycle. A fresh frame 00 01 7F 81 -> loaded = 1, pc = 0 -> 0x7F.
6. Drive reset low between clock edges during S_DATA, and again during S_RUN -> core_reset = 1, loaded = 0 and irom_out = 0x00 before the next edge. After release the loader accepts a new frame from LEN_HI.
